// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// The master modport is the core/RAM side; the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          grant_d;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_d
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_d
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and load/store; one access at a time, IDLE->ISSUE->WAIT->DONE.
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);

  state_t     state, state_nx;
  logic       last_grant;
  logic       grant_nx;
  logic       we_q;
  logic [2:0] cnt;

  // Data wins only if fetch is idle or fetch owned the previous transaction.
  assign grant_nx = bus.d_req & (~bus.i_req | ~last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.i_req || bus.d_req) state_nx = ISSUE;
      ISSUE: state_nx = we_q ? DONE : WAIT;
      WAIT:  if (cnt == LAT_C) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= 1'b1;
      bus.grant_d   <= 1'b0;
      we_q          <= 1'b0;
      cnt           <= 3'd0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_req || bus.d_req) begin
          bus.grant_d   <= grant_nx;
          last_grant    <= grant_nx;
          bus.mem_addr  <= grant_nx ? bus.d_addr : bus.i_addr;
          we_q          <= grant_nx & bus.d_we;
          bus.mem_wdata <= bus.d_wdata;
        end
        ISSUE: cnt <= 3'd1;
        WAIT: begin
          if (cnt == LAT_C) begin
            if (bus.grant_d) bus.d_rdata <= bus.mem_rdata;
            else             bus.i_rdata <= bus.mem_rdata;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode the state register only, so reset kills them immediately.
  assign bus.mem_en = (state == ISSUE);
  assign bus.mem_we = (state == ISSUE) & we_q;
  assign bus.i_done = (state == DONE) & ~bus.grant_d;
  assign bus.d_done = (state == DONE) &  bus.grant_d;
  assign bus.busy   = (state != IDLE);
endmodule
